// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from the fetch PC; training, alias cleanup and statistics happen at EX resolution.
module branch_target_buffer #(
    parameter int IDX_W = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] if_pc_i,
    output logic        br_sel_BTB_o,
    output logic [31:0] predicted_pc_o,
    input  logic        ex_valid_i,
    input  logic        ex_is_branch_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_br_sel_BTB_i,
    input  logic [31:0] ex_predicted_pc_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispredict_cnt_o
);

    localparam int NENT  = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [NENT-1:0]            valid_q, valid_d;
    logic [NENT-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [NENT-1:0][31:0]      target_q, target_d;
    logic [NENT-1:0][1:0]       ctr_q, ctr_d;
    logic [31:0]                branch_cnt_q, branch_cnt_d;
    logic [31:0]                mispredict_cnt_q, mispredict_cnt_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             upd, stale;
    logic [31:0]      actual_next;

    // Fetch-side lookup reads only the registered state, so a same-cycle update shows up next cycle.
    assign if_idx         = if_pc_i[IDX_W+1:2];
    assign if_tag         = if_pc_i[31:IDX_W+2];
    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign br_sel_BTB_o   = if_hit && ctr_q[if_idx][1];
    assign predicted_pc_o = br_sel_BTB_o ? target_q[if_idx] : if_pc_i + 32'd4;

    assign ex_idx = ex_pc_i[IDX_W+1:2];
    assign ex_tag = ex_pc_i[31:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign upd    = ex_valid_i && ex_is_branch_i;
    // A non-branch that was predicted taken hit an entry belonging to another PC.
    assign stale  = ex_valid_i && !ex_is_branch_i && ex_br_sel_BTB_i;

    assign actual_next      = (ex_is_branch_i && ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;
    assign mispredict_o     = ex_valid_i && (actual_next != ex_predicted_pc_i);
    assign redirect_pc_o    = mispredict_o ? actual_next : 32'd0;
    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd) begin
            if (ex_hit) begin
                if (ex_taken_i) begin
                    if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
                    target_d[ex_idx] = ex_target_i;
                end else if (ctr_q[ex_idx] != 2'b00) begin
                    ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
                end
            end else if (ex_taken_i) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = ex_target_i;
                ctr_d[ex_idx]    = 2'b10;
            end
        end else if (stale) begin
            valid_d[ex_idx] = 1'b0;
        end
    end

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (upd && (branch_cnt_q != 32'hFFFF_FFFF))              branch_cnt_d     = branch_cnt_q + 32'd1;
        if (mispredict_o && (mispredict_cnt_q != 32'hFFFF_FFFF)) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q          <= '0;
            tag_q            <= '0;
            target_q         <= '0;
            ctr_q            <= {NENT{2'b01}};
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            valid_q          <= valid_d;
            tag_q            <= tag_d;
            target_q         <= target_d;
            ctr_q            <= ctr_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: driver pushes expectations from a table-based model,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_target_buffer;

    localparam int IDX_W = 4;
    localparam int NENT  = 1 << IDX_W;

    logic        clk, rst_ni;
    logic [31:0] if_pc;
    logic        br_sel;
    logic [31:0] pred_pc;
    logic        ex_valid, ex_is_branch, ex_taken, ex_br_sel;
    logic [31:0] ex_pc, ex_target, ex_pred_pc;
    logic        mispred;
    logic [31:0] redir_pc, bcnt, mcnt;

    branch_target_buffer #(.IDX_W(IDX_W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .if_pc_i(if_pc),
        .br_sel_BTB_o(br_sel), .predicted_pc_o(pred_pc),
        .ex_valid_i(ex_valid), .ex_is_branch_i(ex_is_branch), .ex_pc_i(ex_pc),
        .ex_taken_i(ex_taken), .ex_target_i(ex_target),
        .ex_br_sel_BTB_i(ex_br_sel), .ex_predicted_pc_i(ex_pred_pc),
        .mispredict_o(mispred), .redirect_pc_o(redir_pc),
        .branch_cnt_o(bcnt), .mispredict_cnt_o(mcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        br;
        logic [31:0] pred;
        logic        mis;
        logic [31:0] redir;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: one record per index, plain arithmetic on the PC.
    bit          m_valid[NENT];
    longint      m_tag[NENT];
    logic [31:0] m_tgt[NENT];
    int          m_ctr[NENT];
    longint      m_bcnt, m_mcnt;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic longint tag_of(logic [31:0] pc);
        return longint'(pc) / (4 * NENT);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_bcnt = 0; m_mcnt = 0;
    endtask

    task automatic m_lookup(input logic [31:0] pc, output logic br, output logic [31:0] pred);
        int i;
        i    = idx_of(pc);
        br   = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
        pred = br ? m_tgt[i] : pc + 32'd4;
    endtask

    function automatic logic [31:0] m_actual();
        return (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
    endfunction

    task automatic m_apply();
        int i;
        i = idx_of(ex_pc);
        if (ex_valid && (m_actual() != ex_pred_pc) && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
        if (ex_valid && ex_is_branch) begin
            if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
            if (m_valid[i] && m_tag[i] == tag_of(ex_pc)) begin
                if (ex_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = ex_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (ex_taken) begin
                m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target; m_ctr[i] = 2;
            end
        end else if (ex_valid && ex_br_sel) begin
            m_valid[i] = 0;
        end
    endtask

    // Expectation for the currently driven inputs; literal values override the model for directed steps.
    task automatic push_exp(input string nm, input bit lit, input logic lbr, input logic [31:0] lpred,
                            input logic lmis, input logic [31:0] lredir);
        exp_t        e;
        logic [31:0] act;
        e.name = nm;
        m_lookup(if_pc, e.br, e.pred);
        act     = m_actual();
        e.mis   = ex_valid && (act != ex_pred_pc);
        e.redir = e.mis ? act : 32'd0;
        e.bcnt  = m_bcnt[31:0];
        e.mcnt  = m_mcnt[31:0];
        if (lit) begin
            e.br = lbr; e.pred = lpred; e.mis = lmis; e.redir = lredir;
        end
        sb.push_back(e);
    endtask

    task automatic drive(input logic [31:0] ip, input logic v, input logic b, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tg, input logic bs, input logic [31:0] pp);
        if_pc = ip; ex_valid = v; ex_is_branch = b; ex_pc = pc;
        ex_taken = tk; ex_target = tg; ex_br_sel = bs; ex_pred_pc = pp;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        if (rst_ni) m_apply();
        #1;
    endtask

    task automatic dstep(input string nm, input logic [31:0] ip, input logic v, input logic b,
                         input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic bs,
                         input logic [31:0] pp, input logic ebr, input logic [31:0] epred,
                         input logic emis, input logic [31:0] eredir);
        drive(ip, v, b, pc, tk, tg, bs, pp);
        push_exp(nm, 1'b1, ebr, epred, emis, eredir);
        finish_cycle();
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, NENT - 1)) << 2)
            | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) p = $urandom;
        if ($urandom_range(0, 31) == 0) p = 32'hFFFF_FFFC;
        return p;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "br_sel", {31'd0, br_sel}, {31'd0, e.br});
            chk(e.name, "pred_pc", pred_pc, e.pred);
            chk(e.name, "mispredict", {31'd0, mispred}, {31'd0, e.mis});
            chk(e.name, "redirect", redir_pc, e.redir);
            chk(e.name, "branch_cnt", bcnt, e.bcnt);
            chk(e.name, "mispred_cnt", mcnt, e.mcnt);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        lbr;
        logic [31:0] lpred, p;
        rst_ni = 1'b0;
        m_reset();
        drive(32'h100, 0, 0, 0, 0, 0, 0, 0);
        push_exp("reset", 1'b1, 1'b0, 32'h104, 1'b0, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_ni = 1'b1;

        dstep("alloc", 32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 32'h104, 1, 32'h200);
        dstep("hit_tk", 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 32'h0);
        dstep("nt1", 32'h100, 1, 1, 32'h100, 0, 32'h200, 1, 32'h200, 1, 32'h200, 1, 32'h104);
        dstep("nt2", 32'h100, 1, 1, 32'h100, 0, 32'h200, 0, 32'h104, 0, 32'h104, 0, 32'h0);
        dstep("after_nt", 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 32'h0);
        dstep("retrain1", 32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 32'h104, 1, 32'h200);
        dstep("retrain2", 32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 32'h104, 1, 32'h200);
        dstep("alias", 32'h100, 1, 0, 32'h140, 0, 0, 1, 32'h200, 1, 32'h200, 1, 32'h144);
        dstep("post_alias", 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 32'h0);
        dstep("wrap", 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        dstep("alloc180", 32'h100, 1, 1, 32'h180, 1, 32'h300, 0, 32'h184, 0, 32'h104, 1, 32'h300);
        dstep("hit180", 32'h180, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 32'h0);

        // Reset asserted mid-period while an allocating update is pending.
        drive(32'h180, 1, 1, 32'h1C4, 1, 32'h500, 0, 32'h1C8);
        #1 rst_ni = 1'b0;
        m_reset();
        push_exp("mid_reset", 1'b1, 1'b0, 32'h184, 1'b1, 32'h500);
        finish_cycle();
        ex_valid = 1'b0;
        rst_ni   = 1'b1;
        dstep("no_write", 32'h1C4, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1C8, 0, 32'h0);
        dstep("cleared", 32'h180, 0, 0, 0, 0, 0, 0, 0, 0, 32'h184, 0, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            p = rpc();
            m_lookup(p, lbr, lpred);
            drive(($urandom_range(0, 3) == 0) ? p : rpc(), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 3) != 0, p, $urandom_range(0, 1) == 1, rpc(),
                  ($urandom_range(0, 3) != 0) ? lbr : 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0) ? lpred : rpc());
            push_exp("rand", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            finish_cycle();
        end

        ex_valid = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
